// File: rtl/beat_sequencer.sv
// Machine-cycle timing generator: one-hot beats w1..w3, each split into phases t1..t3,
// with short/long/stop shaping of the instruction and run/single-step control.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | halted, all beat/phase outputs low, waiting for a qd rising edge
// S_RUN  | stepping phases t1->t2->t3, beat decision taken on every t3
module beat_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             qd,
    input  logic             step,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_1    = 2'd1;
    localparam logic [1:0] PH_3    = 2'd3;
    localparam logic [1:0] BT_NONE = 2'd0;
    localparam logic [1:0] BT_1    = 2'd1;
    localparam logic [1:0] BT_2    = 2'd2;
    localparam logic [1:0] BT_3    = 2'd3;

    state_t     state, state_nxt;
    logic [1:0] phase, phase_nxt;
    logic [1:0] beat, beat_nxt;
    logic       qd_d;
    logic       qd_rise;
    logic       beat_final;
    logic       count_en;

    assign qd_rise = qd & ~qd_d;

    // short wins over long in w1 simply because long is only looked at in w2
    assign beat_final = ((beat == BT_1) & short)
                      | ((beat == BT_2) & ~long)
                      |  (beat == BT_3);

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_IDLE;
            phase  <= PH_NONE;
            beat   <= BT_NONE;
            qd_d   <= 1'b0;
            icount <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            beat  <= beat_nxt;
            qd_d  <= qd;
            if (count_en) begin
                icount <= icount + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        beat_nxt  = beat;
        count_en  = 1'b0;
        case (state)
            S_IDLE: begin
                phase_nxt = PH_NONE;
                beat_nxt  = BT_NONE;
                if (qd_rise) begin
                    state_nxt = S_RUN;
                    phase_nxt = PH_1;
                    beat_nxt  = BT_1;
                end
            end
            S_RUN: begin
                if (phase != PH_3) begin
                    phase_nxt = phase + 2'd1;
                end else if (stop) begin
                    state_nxt = S_IDLE;
                    phase_nxt = PH_NONE;
                    beat_nxt  = BT_NONE;
                end else if (beat_final) begin
                    count_en = 1'b1;
                    if (step) begin
                        state_nxt = S_IDLE;
                        phase_nxt = PH_NONE;
                        beat_nxt  = BT_NONE;
                    end else begin
                        phase_nxt = PH_1;
                        beat_nxt  = BT_1;
                    end
                end else begin
                    phase_nxt = PH_1;
                    beat_nxt  = beat + 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = PH_NONE;
                beat_nxt  = BT_NONE;
            end
        endcase
    end

    // Decoded purely from registers; phase/beat are forced to 0 whenever idle.
    always_comb begin
        running = (state == S_RUN);
        t1      = (phase == 2'd1);
        t2      = (phase == 2'd2);
        t3      = (phase == 2'd3);
        w1      = (beat == BT_1);
        w2      = (beat == BT_2);
        w3      = (beat == BT_3);
    end

endmodule
